// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache-side memory arbiter.
package cache_pkg;

    localparam int ADR_WIDTH         = 32;
    localparam int WORD_WIDTH        = 32;
    localparam int BURST_LEN         = 4;
    localparam int WORD_OFFSET_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Line base: word offset and byte-in-word bits cleared.
    function automatic logic [ADR_WIDTH-1:0] line_base(input logic [ADR_WIDTH-1:0] adr);
        return {adr[ADR_WIDTH-1:WORD_OFFSET_WIDTH+2], {(WORD_OFFSET_WIDTH+2){1'b0}}};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             vld
);

    int idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port among N_REQ cache requesters, one full-line burst per grant.
// Optional macro CACHE_ARB_WB_PRIORITY_EN: requester 0 (writeback) always wins in IDLE.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ*ADR_WIDTH-1:0]    adr_i,
    input  logic [N_REQ-1:0]              rdwr_i,
    input  logic [N_REQ*WORD_WIDTH-1:0]   wdat_i,
    output logic [N_REQ-1:0]              gnt_o,
    output logic [WORD_OFFSET_WIDTH-1:0]  word_idx_o,
    output logic [N_REQ-1:0]              word_ack_o,
    output logic [WORD_WIDTH-1:0]         rdat_o,
    output logic [N_REQ-1:0]              done_o,
    output logic                          mem_req_o,
    output logic [ADR_WIDTH-1:0]          mem_adr_o,
    output logic                          mem_rdwr_o,
    output logic [WORD_WIDTH-1:0]         mem_dat_o,
    input  logic                          mem_ack_i,
    input  logic [WORD_WIDTH-1:0]         mem_dat_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t                   state;
    logic [PTR_W-1:0]             rr_ptr;
    logic [PTR_W-1:0]             gnt_idx;
    logic [N_REQ-1:0]             gnt_q;
    logic [WORD_OFFSET_WIDTH-1:0] word_cnt;
    logic [ADR_WIDTH-1:0]         base;
    logic                         rdwr_q;

    logic [N_REQ-1:0]             rr_gnt;
    logic                         rr_vld;
    logic [N_REQ-1:0]             sel_gnt;
    logic [PTR_W-1:0]             sel_idx;
    logic [ADR_WIDTH-1:0]         sel_adr;
    logic                         sel_rdwr;
    logic [WORD_WIDTH-1:0]        wdat_sel;
    logic [PTR_W-1:0]             next_ptr;
    logic                         in_burst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .vld (rr_vld)
    );

    always_comb begin
        sel_gnt = rr_gnt;
`ifdef CACHE_ARB_WB_PRIORITY_EN
        if (req_i[0]) begin
            sel_gnt    = '0;
            sel_gnt[0] = 1'b1;
        end
`endif
        sel_idx  = '0;
        sel_adr  = '0;
        sel_rdwr = 1'b0;
        wdat_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel_gnt[k]) begin
                sel_idx  = PTR_W'(k);
                sel_adr  = adr_i[k*ADR_WIDTH +: ADR_WIDTH];
                sel_rdwr = rdwr_i[k];
            end
            if (gnt_idx == PTR_W'(k)) begin
                wdat_sel = wdat_i[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_comb begin
        next_ptr = (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
`ifdef CACHE_ARB_WB_PRIORITY_EN
        // Writeback grants bypass the rotation so refills keep their turn.
        if (gnt_idx == '0) begin
            next_ptr = rr_ptr;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            gnt_q    <= '0;
            word_cnt <= '0;
            base     <= '0;
            rdwr_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_vld) begin
                        state   <= BURST;
                        gnt_q   <= sel_gnt;
                        gnt_idx <= sel_idx;
                        rdwr_q  <= sel_rdwr;
                        base    <= line_base(sel_adr);
                    end
                end
                BURST: begin
                    if (mem_ack_i) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == WORD_OFFSET_WIDTH'(BURST_LEN-1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    rr_ptr <= next_ptr;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_burst   = (state == BURST);
    assign gnt_o      = gnt_q;
    assign word_idx_o = word_cnt;
    assign done_o     = (state == DONE) ? gnt_q : '0;
    assign mem_req_o  = in_burst;
    assign mem_adr_o  = in_burst ? (base | (ADR_WIDTH'(word_cnt) << 2)) : '0;
    assign mem_rdwr_o = in_burst & rdwr_q;
    assign mem_dat_o  = in_burst ? wdat_sel : '0;
    assign word_ack_o = (in_burst && mem_ack_i) ? gnt_q : '0;
    assign rdat_o     = (in_burst && mem_ack_i) ? mem_dat_i : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus queues expected words/done pulses, a monitor checks them.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_i = '0;
    logic [95:0] adr_i = '0;
    logic [2:0]  rdwr_i = '0;
    logic [95:0] wdat_i;
    logic [2:0]  gnt_o, word_ack_o, done_o;
    logic [1:0]  word_idx_o;
    logic [31:0] rdat_o, mem_adr_o, mem_dat_o;
    logic        mem_req_o, mem_rdwr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_dat_i = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_mode = 0;
    bit stray_ack = 1'b1;

    typedef struct {
        logic [2:0]  gnt;
        logic [1:0]  idx;
        logic [31:0] adr;
        logic        rdwr;
        logic [31:0] wdat;
        logic [31:0] rdat;
    } exp_t;

    exp_t       wq[$];
    logic [2:0] dq[$];

    cache_mem_arbiter #(.N_REQ(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .adr_i      (adr_i),
        .rdwr_i     (rdwr_i),
        .wdat_i     (wdat_i),
        .gnt_o      (gnt_o),
        .word_idx_o (word_idx_o),
        .word_ack_o (word_ack_o),
        .rdat_o     (rdat_o),
        .done_o     (done_o),
        .mem_req_o  (mem_req_o),
        .mem_adr_o  (mem_adr_o),
        .mem_rdwr_o (mem_rdwr_o),
        .mem_dat_o  (mem_dat_o),
        .mem_ack_i  (mem_ack_i),
        .mem_dat_i  (mem_dat_i)
    );

    always #5 clk = ~clk;

    // Requesters present a distinct write word per requester and word index.
    always_comb begin
        wdat_i = '0;
        for (int k = 0; k < 3; k++) begin
            wdat_i[k*32 +: 32] = 32'hC0DE_0000 + 32'(k*16) + 32'(word_idx_o);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic push_burst(input int r, input logic [31:0] base, input logic rdwr,
                              input int nwords, input bit with_done);
        exp_t e;
        for (int i = 0; i < nwords; i++) begin
            e.gnt  = 3'(1 << r);
            e.idx  = 2'(i);
            e.adr  = base + 32'(4*i);
            e.rdwr = rdwr;
            e.wdat = 32'hC0DE_0000 + 32'(r*16) + 32'(i);
            e.rdat = 32'hA0 + 32'(i);
            wq.push_back(e);
        end
        if (with_done) dq.push_back(3'(1 << r));
    endtask

    task automatic wait_done(input logic [2:0] mask);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(posedge clk); #1;
            if ((done_o & mask) != 0) hit = 1'b1;
        end
        chk("done_wait", 32'(hit), 32'd1);
    endtask

    task automatic wait_idx(input logic [1:0] v);
        bit hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #1;
            if (mem_req_o && word_idx_o == v) hit = 1'b1;
        end
        chk("idx_wait", 32'(hit), 32'd1);
    endtask

    // Memory model: acks every cycle or every third cycle of a burst, stray acks while idle.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_req_o) begin
                cnt++;
                mem_ack_i = (ack_mode == 0) ? 1'b1 : (cnt % 3 == 0);
            end else begin
                cnt = 0;
                mem_ack_i = stray_ack;
            end
            mem_dat_i = 32'hA0 + 32'(word_idx_o);
        end
    end

    // Monitor: pops expected words on word_ack_o and expected pulses on done_o.
    initial begin
        exp_t        e;
        logic [2:0]  d;
        logic        prev_req = 1'b0, prev_ack = 1'b0;
        logic [1:0]  prev_idx = '0;
        logic [31:0] prev_adr = '0;
        int          low_cnt = 0;
        bit          seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (word_ack_o != 0) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_ack", 32'(word_ack_o), 32'd0);
                    end else begin
                        e = wq.pop_front();
                        chk("word_ack", 32'(word_ack_o), 32'(e.gnt));
                        chk("gnt", 32'(gnt_o), 32'(e.gnt));
                        chk("word_idx", 32'(word_idx_o), 32'(e.idx));
                        chk("mem_adr", mem_adr_o, e.adr);
                        chk("mem_rdwr", 32'(mem_rdwr_o), 32'(e.rdwr));
                        chk("rdat", rdat_o, e.rdat);
                        if (e.rdwr) chk("mem_dat", mem_dat_o, e.wdat);
                    end
                end
                if (done_o != 0) begin
                    if (dq.size() == 0) begin
                        chk("unexpected_done", 32'(done_o), 32'd0);
                    end else begin
                        d = dq.pop_front();
                        chk("done", 32'(done_o), 32'(d));
                        chk("done_mem_req", 32'(mem_req_o), 32'd0);
                    end
                end
                if (mem_req_o && prev_req && !prev_ack) begin
                    chk("stall_idx", 32'(word_idx_o), 32'(prev_idx));
                    chk("stall_adr", mem_adr_o, prev_adr);
                end
                if (mem_req_o && !prev_req) begin
                    if (seen) chk("dead_time", 32'(low_cnt >= 2), 32'd1);
                    seen = 1'b1;
                    low_cnt = 0;
                end else if (!mem_req_o) begin
                    low_cnt++;
                end
                prev_req = mem_req_o;
                prev_ack = (word_ack_o != 0);
                prev_idx = word_idx_o;
                prev_adr = mem_adr_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit drained = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_word_ack", 32'(word_ack_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_adr", mem_adr_o, 32'd0);
        chk("rst_mem_dat", mem_dat_o, 32'd0);
        chk("rst_rdat", rdat_o, 32'd0);
        chk("rst_word_idx", 32'(word_idx_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("idle_stray_ack", 32'(word_ack_o), 32'd0);

        // Single read from requester 1.
        adr_i[32 +: 32] = 32'h0000_1238;
        rdwr_i = 3'b000;
        push_burst(1, 32'h0000_1230, 1'b0, 4, 1'b1);
        req_i = 3'b010;
        wait_done(3'b010);
        req_i = 3'b000;

        // Write burst from requester 0 with memory acking every third cycle.
        adr_i[0 +: 32] = 32'h0000_4000;
        rdwr_i = 3'b001;
        ack_mode = 1;
        push_burst(0, 32'h0000_4000, 1'b1, 4, 1'b1);
        req_i = 3'b001;
        wait_done(3'b001);
        req_i = 3'b000;
        ack_mode = 0;
        rdwr_i = 3'b000;

        // Requester 2 drops its request and scrambles address/direction mid-burst.
        adr_i[64 +: 32] = 32'h0000_8008;
        push_burst(2, 32'h0000_8000, 1'b0, 4, 1'b1);
        req_i = 3'b100;
        wait_idx(2'd2);
        req_i = 3'b000;
        adr_i[64 +: 32] = 32'hFFFF_FFF0;
        rdwr_i[2] = 1'b1;
        wait_done(3'b100);
        rdwr_i = 3'b000;

        // All three requesting continuously.
        adr_i[0  +: 32] = 32'h0000_0100;
        adr_i[32 +: 32] = 32'h0000_0210;
        adr_i[64 +: 32] = 32'h0000_032C;
`ifdef CACHE_ARB_WB_PRIORITY_EN
        for (int b = 0; b < 4; b++) push_burst(0, 32'h0000_0100, 1'b0, 4, 1'b1);
`else
        push_burst(0, 32'h0000_0100, 1'b0, 4, 1'b1);
        push_burst(1, 32'h0000_0210, 1'b0, 4, 1'b1);
        push_burst(2, 32'h0000_0320, 1'b0, 4, 1'b1);
        push_burst(0, 32'h0000_0100, 1'b0, 4, 1'b1);
`endif
        req_i = 3'b111;
        for (int b = 0; b < 4; b++) wait_done(3'b111);
        req_i = 3'b000;
`ifdef CACHE_ARB_WB_PRIORITY_EN
        push_burst(1, 32'h0000_0210, 1'b0, 4, 1'b1);
        push_burst(2, 32'h0000_0320, 1'b0, 4, 1'b1);
        push_burst(1, 32'h0000_0210, 1'b0, 4, 1'b1);
        req_i = 3'b110;
        for (int b = 0; b < 3; b++) wait_done(3'b110);
        req_i = 3'b000;
`endif

        // Reset during word 2 of a requester-2 burst; no done pulse may follow.
        push_burst(2, 32'h0000_0320, 1'b0, 2, 1'b0);
        req_i = 3'b100;
        wait_idx(2'd2);
        rst = 1'b1;
        req_i = 3'b000;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_mem_req", 32'(mem_req_o), 32'd0);
        chk("abort_gnt", 32'(gnt_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_word_idx", 32'(word_idx_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        push_burst(0, 32'h0000_0100, 1'b0, 4, 1'b1);
        req_i = 3'b011;
        wait_done(3'b011);
        req_i = 3'b000;

        for (int i = 0; i < 50 && !drained; i++) begin
            @(posedge clk); #1;
            if (wq.size() == 0 && dq.size() == 0) drained = 1'b1;
        end
        chk("scoreboard_drain", 32'(wq.size() + dq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
